// File: rtl/wrn_mqueue_pkg.sv
// Shared types for the MQueue UDP receive path: mt stream structs, UDP header record, deframer FSM states.
// Header word counts are in 16-bit words.
package wrn_mqueue_pkg;

    localparam int          c_IPV4_HDR_WORDS = 10;
    localparam int          c_UDP_HDR_WORDS  = 4;
    localparam int          c_HDR_LAST_WORD  = c_IPV4_HDR_WORDS + c_UDP_HDR_WORDS - 1;
    localparam logic [7:0]  c_IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  c_IPV4_VER_IHL   = 8'h45;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
        logic        last;
    } t_mt_stream_sink_in;

    typedef struct packed {
        logic ready;
    } t_mt_stream_sink_out;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
        logic        last;
    } t_mt_stream_source_out;

    typedef struct packed {
        logic ready;
    } t_mt_stream_source_in;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] length;
    } t_mt_udp_rx_hdr;

    typedef enum logic [1:0] {
        HDR,
        PAYLOAD,
        DROP
    } t_udp_rx_state;

endpackage

// File: rtl/mt_ipv4_csum_acc.sv
// 16-bit ones-complement accumulator with end-around carry; clr restarts the sum, en adds dat.
// Result is registered one cycle after the last add.
module mt_ipv4_csum_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] dat,
    output logic [15:0] sum
);

    logic [15:0] base;
    logic [16:0] raw;
    logic [15:0] folded;

    always_comb begin
        base   = clr ? 16'h0000 : sum;
        raw    = {1'b0, base} + {1'b0, dat};
        folded = raw[15:0] + {15'd0, raw[16]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum <= 16'h0000;
        end else if (en) begin
            sum <= folded;
        end else if (clr) begin
            sum <= 16'h0000;
        end
    end

endmodule

// File: rtl/mt_udp_rx_deframer.sv
// IPv4/UDP receive deframer: checks headers, exposes fields, forwards only UDP payload (1-clk register stage).
// MT_UDP_RX_CSUM_CHECK_EN adds an IPv4 header checksum check; default build ignores the checksum.
module mt_udp_rx_deframer
    import wrn_mqueue_pkg::*;
#(
    parameter bit          g_dst_port_filter = 1'b0,
    parameter logic [15:0] g_dst_port        = 16'hebd1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  t_mt_stream_sink_in    snk_i,
    output t_mt_stream_sink_out   snk_o,
    output t_mt_stream_source_out src_o,
    input  t_mt_stream_source_in  src_i,
    output logic                  p_header_valid_o,
    output logic [31:0]           p_src_ip_o,
    output logic [31:0]           p_dst_ip_o,
    output logic [15:0]           p_src_port_o,
    output logic [15:0]           p_dst_port_o,
    output logic [15:0]           p_udp_length_o,
    output logic                  p_drop_o,
    output logic                  p_trunc_o
);

    t_udp_rx_state         state_q, state_d;
    logic [3:0]            cnt_q;
    logic                  bad_q;
    t_mt_udp_rx_hdr        hdr_q;
    logic [15:0]           left_q;
    t_mt_stream_source_out src_q;
    logic                  hv_q, hv_pulse_q, drop_q, trunc_q;

    logic        rdy, acc, last_hdr, hdr_fail, csum_fail;
    logic [15:0] n_words;
    logic        drop_d, trunc_d, hv_set, hv_n0, load, ld_last;

    // Upper half of the input word carries nothing on this 16-bit path.
    logic unused_hi;
    assign unused_hi = ^snk_i.data[31:16];

    assign rdy      = rst_n_i & ((state_q == PAYLOAD) ? (!src_q.valid | src_i.ready) : 1'b1);
    assign acc      = snk_i.valid & rdy;
    assign last_hdr = (cnt_q == 4'(c_HDR_LAST_WORD));
    assign n_words  = (hdr_q.length - 16'd7) >> 1;

`ifdef MT_UDP_RX_CSUM_CHECK_EN
    logic [15:0] csum_sum;

    mt_ipv4_csum_acc u_csum (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .clr   (state_q == HDR && acc && cnt_q == 4'd0),
        .en    (state_q == HDR && acc && cnt_q <= 4'(c_IPV4_HDR_WORDS - 1)),
        .dat   (snk_i.data[15:0]),
        .sum   (csum_sum)
    );
    assign csum_fail = (csum_sum != 16'hffff);
`else
    assign csum_fail = 1'b0;
`endif

    assign hdr_fail = bad_q | (hdr_q.length < 16'd8) | csum_fail |
                      (g_dst_port_filter && (hdr_q.dst_port != g_dst_port));

    always_comb begin
        state_d = state_q;
        drop_d  = 1'b0;
        trunc_d = 1'b0;
        hv_set  = 1'b0;
        hv_n0   = 1'b0;
        load    = 1'b0;
        ld_last = 1'b0;
        case (state_q)
            HDR: begin
                if (acc) begin
                    if (last_hdr) begin
                        if (hdr_fail) begin
                            drop_d  = 1'b1;
                            state_d = snk_i.last ? HDR : DROP;
                        end else if (n_words == 16'd0) begin
                            hv_set  = 1'b1;
                            hv_n0   = 1'b1;
                            state_d = snk_i.last ? HDR : DROP;
                        end else if (snk_i.last) begin
                            // header promised payload but the frame ended right after it
                            trunc_d = 1'b1;
                        end else begin
                            hv_set  = 1'b1;
                            state_d = PAYLOAD;
                        end
                    end else if (snk_i.last) begin
                        drop_d = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (acc) begin
                    load    = 1'b1;
                    ld_last = snk_i.last | (left_q == 16'd1);
                    trunc_d = snk_i.last & (left_q != 16'd1);
                    if (ld_last) begin
                        state_d = snk_i.last ? HDR : DROP;
                    end
                end
            end
            DROP: begin
                if (acc && snk_i.last) begin
                    state_d = HDR;
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= HDR;
            cnt_q      <= 4'd0;
            bad_q      <= 1'b0;
            hdr_q      <= '0;
            left_q     <= 16'd0;
            src_q      <= '0;
            hv_q       <= 1'b0;
            hv_pulse_q <= 1'b0;
            drop_q     <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            trunc_q    <= trunc_d;
            hv_pulse_q <= hv_n0;

            if (state_q == HDR && acc) begin
                cnt_q <= (last_hdr || snk_i.last) ? 4'd0 : cnt_q + 4'd1;
                case (cnt_q)
                    4'd0:  bad_q <= (snk_i.data[15:8] != c_IPV4_VER_IHL);
                    4'd4:  bad_q <= bad_q | (snk_i.data[7:0] != c_IP_PROTO_UDP);
                    4'd6:  hdr_q.src_ip[31:16] <= snk_i.data[15:0];
                    4'd7:  hdr_q.src_ip[15:0]  <= snk_i.data[15:0];
                    4'd8:  hdr_q.dst_ip[31:16] <= snk_i.data[15:0];
                    4'd9:  hdr_q.dst_ip[15:0]  <= snk_i.data[15:0];
                    4'd10: hdr_q.src_port      <= snk_i.data[15:0];
                    4'd11: hdr_q.dst_port      <= snk_i.data[15:0];
                    4'd12: hdr_q.length        <= snk_i.data[15:0];
                    default: ;
                endcase
            end

            if (hv_set) begin
                left_q <= n_words;
            end else if (load) begin
                left_q <= left_q - 16'd1;
            end

            // header_valid spans the payload until its final word leaves the output register
            if (hv_set) begin
                hv_q <= 1'b1;
            end else if (hv_pulse_q || (src_q.valid && src_i.ready && src_q.last)) begin
                hv_q <= 1'b0;
            end

            if (src_q.valid && src_i.ready) begin
                src_q.valid <= 1'b0;
                src_q.last  <= 1'b0;
            end
            if (load) begin
                src_q.valid <= 1'b1;
                src_q.data  <= {16'h0000, snk_i.data[15:0]};
                src_q.last  <= ld_last;
            end
        end
    end

    assign snk_o.ready      = rdy;
    assign src_o            = src_q;
    assign p_header_valid_o = hv_q;
    assign p_src_ip_o       = hdr_q.src_ip;
    assign p_dst_ip_o       = hdr_q.dst_ip;
    assign p_src_port_o     = hdr_q.src_port;
    assign p_dst_port_o     = hdr_q.dst_port;
    assign p_udp_length_o   = hdr_q.length;
    assign p_drop_o         = drop_q;
    assign p_trunc_o        = trunc_q;

endmodule

// File: tb/tb_mt_udp_rx_deframer.sv
// Bench for mt_udp_rx_deframer: throttled source/sink, scoreboard of expected payload words.
module tb_mt_udp_rx_deframer;
    import wrn_mqueue_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    t_mt_stream_sink_in    snk_i;
    t_mt_stream_sink_out   snk_o;
    t_mt_stream_source_out src_o;
    t_mt_stream_source_in  src_i;
    logic        p_header_valid_o, p_drop_o, p_trunc_o;
    logic [31:0] p_src_ip_o, p_dst_ip_o;
    logic [15:0] p_src_port_o, p_dst_port_o, p_udp_length_o;

    mt_udp_rx_deframer dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .snk_i            (snk_i),
        .snk_o            (snk_o),
        .src_o            (src_o),
        .src_i            (src_i),
        .p_header_valid_o (p_header_valid_o),
        .p_src_ip_o       (p_src_ip_o),
        .p_dst_ip_o       (p_dst_ip_o),
        .p_src_port_o     (p_src_port_o),
        .p_dst_port_o     (p_dst_port_o),
        .p_udp_length_o   (p_udp_length_o),
        .p_drop_o         (p_drop_o),
        .p_trunc_o        (p_trunc_o)
    );

    typedef struct {
        logic [15:0] dat;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] fr[$];
    int n_cmp = 0;
    int n_err = 0;
    int thr = 50;
    int drop_cnt = 0, trunc_cnt = 0, hv_rise = 0, hv_cycles = 0;
    logic hv_prev = 1'b0;

    // Sink side: throttled ready, scoreboard pop, pulse counters. Outputs only move at posedge.
    always @(negedge clk) begin
        exp_t e;
        src_i.ready = ($urandom_range(99) >= thr);
        if (rst_n) begin
            if (p_drop_o) drop_cnt++;
            if (p_trunc_o) trunc_cnt++;
            if (p_header_valid_o) hv_cycles++;
            if (p_header_valid_o && !hv_prev) hv_rise++;
            hv_prev = p_header_valid_o;
            if (src_o.valid && src_i.ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word got %h/last=%b expected no word", src_o.data, src_o.last);
                end else begin
                    e = exp_q.pop_front();
                    if (src_o.data !== {16'h0000, e.dat} || src_o.last !== e.last) begin
                        n_err++;
                        $display("FAIL payload_word got %h/last=%b expected %h/last=%b",
                                 src_o.data, src_o.last, {16'h0000, e.dat}, e.last);
                    end
                end
            end
        end
    end

    task automatic mk_hdr(input logic [7:0] proto, input logic [31:0] sip, input logic [31:0] dip,
                          input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len);
        logic [31:0] sum;
        fr.delete();
        fr.push_back(16'h4500);
        fr.push_back(16'd20 + len);
        fr.push_back(16'h1234);
        fr.push_back(16'h4000);
        fr.push_back({8'h40, proto});
        fr.push_back(16'h0000);
        fr.push_back(sip[31:16]);
        fr.push_back(sip[15:0]);
        fr.push_back(dip[31:16]);
        fr.push_back(dip[15:0]);
        sum = 32'd0;
        for (int i = 0; i < 10; i++) sum = sum + {16'd0, fr[i]};
        while (sum[31:16] != 16'd0) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        fr[5] = ~sum[15:0];
        fr.push_back(sp);
        fr.push_back(dp);
        fr.push_back(len);
        fr.push_back(16'h0000);
    endtask

    task automatic add_payload(input int n, input logic [15:0] base, input int exp_n, input int exp_last_at);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            fr.push_back(base + 16'(i));
            if (i < exp_n) begin
                e.dat  = base + 16'(i);
                e.last = (i == exp_last_at);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send();
        int w;
        @(negedge clk);
        for (int i = 0; i < fr.size(); i++) begin
            while (thr > 0 && $urandom_range(99) < thr) begin
                snk_i.valid = 1'b0;
                @(negedge clk);
            end
            snk_i.valid = 1'b1;
            snk_i.data  = {16'h0000, fr[i]};
            snk_i.last  = (i == fr.size() - 1);
            w = 0;
            #1;
            while (!snk_o.ready) begin
                @(negedge clk);
                #1;
                w++;
                if (w > 1000) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL input_stall got ready=0 for %0d cycles expected ready", w);
                    snk_i.valid = 1'b0;
                    return;
                end
            end
            @(negedge clk);
        end
        snk_i.valid = 1'b0;
        snk_i.last  = 1'b0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout got %0d words pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        snk_i = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (src_o.valid !== 1'b0) begin n_err++; $display("FAIL rst_src_valid got %b expected 0", src_o.valid); end
        n_cmp++; if (src_o.last !== 1'b0) begin n_err++; $display("FAIL rst_src_last got %b expected 0", src_o.last); end
        n_cmp++; if (snk_o.ready !== 1'b0) begin n_err++; $display("FAIL rst_snk_ready got %b expected 0", snk_o.ready); end
        n_cmp++; if ({p_header_valid_o, p_drop_o, p_trunc_o} !== 3'b000) begin n_err++; $display("FAIL rst_pulses got %b expected 000", {p_header_valid_o, p_drop_o, p_trunc_o}); end
        n_cmp++; if ({p_src_ip_o, p_dst_ip_o, p_src_port_o, p_dst_port_o, p_udp_length_o} !== 112'd0) begin n_err++; $display("FAIL rst_fields got %h expected 0", {p_src_ip_o, p_dst_ip_o}); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (snk_o.ready !== 1'b1) begin n_err++; $display("FAIL hdr_ready got %b expected 1", snk_o.ready); end
    endtask

    task automatic test_valid();
        int d0 = drop_cnt, t0 = trunc_cnt, h0 = hv_rise;
        mk_hdr(8'd17, 32'hc0a80001, 32'hffffffff, 16'h0000, 16'hebd1, 16'd40);
        add_payload(16, 16'd0, 16, 15);
        send();
        wait_done();
        n_cmp++; if (drop_cnt - d0 !== 0) begin n_err++; $display("FAIL valid_drop got %0d expected 0", drop_cnt - d0); end
        n_cmp++; if (trunc_cnt - t0 !== 0) begin n_err++; $display("FAIL valid_trunc got %0d expected 0", trunc_cnt - t0); end
        n_cmp++; if (hv_rise - h0 !== 1) begin n_err++; $display("FAIL valid_hv got %0d expected 1", hv_rise - h0); end
        n_cmp++; if (p_src_ip_o !== 32'hc0a80001 || p_dst_ip_o !== 32'hffffffff) begin n_err++; $display("FAIL valid_ips got %h %h expected c0a80001 ffffffff", p_src_ip_o, p_dst_ip_o); end
        n_cmp++; if (p_src_port_o !== 16'h0000 || p_dst_port_o !== 16'hebd1 || p_udp_length_o !== 16'd40) begin n_err++; $display("FAIL valid_ports got %h %h %h expected 0000 ebd1 0028", p_src_port_o, p_dst_port_o, p_udp_length_o); end
        n_cmp++; if (p_header_valid_o !== 1'b0) begin n_err++; $display("FAIL valid_hv_clear got %b expected 0", p_header_valid_o); end
    endtask

    task automatic test_padding();
        int d0 = drop_cnt, h0 = hv_rise;
        mk_hdr(8'd17, 32'h0a000001, 32'h0a000002, 16'h1111, 16'hebd1, 16'd40);
        add_payload(16, 16'h0100, 16, 15);
        fr.push_back(16'hdead); fr.push_back(16'hbeef); fr.push_back(16'hcafe);
        send();
        mk_hdr(8'd17, 32'h0a000003, 32'h0a000004, 16'h2222, 16'h1234, 16'd13);
        add_payload(3, 16'h0200, 3, 2);
        send();
        wait_done();
        n_cmp++; if (drop_cnt - d0 !== 0) begin n_err++; $display("FAIL pad_drop got %0d expected 0", drop_cnt - d0); end
        n_cmp++; if (hv_rise - h0 !== 2) begin n_err++; $display("FAIL pad_hv got %0d expected 2", hv_rise - h0); end
        n_cmp++; if (p_dst_port_o !== 16'h1234 || p_udp_length_o !== 16'd13) begin n_err++; $display("FAIL pad_fields got %h %h expected 1234 000d", p_dst_port_o, p_udp_length_o); end
    endtask

    task automatic test_proto();
        int d0 = drop_cnt, h0 = hv_rise;
        mk_hdr(8'd6, 32'h01020304, 32'h05060708, 16'h0001, 16'hebd1, 16'd40);
        add_payload(16, 16'h0300, 0, -1);
        send();
        mk_hdr(8'd17, 32'h11223344, 32'h55667788, 16'h0009, 16'hebd1, 16'd12);
        add_payload(2, 16'h0400, 2, 1);
        send();
        wait_done();
        n_cmp++; if (drop_cnt - d0 !== 1) begin n_err++; $display("FAIL proto_drop got %0d expected 1", drop_cnt - d0); end
        n_cmp++; if (hv_rise - h0 !== 1) begin n_err++; $display("FAIL proto_hv got %0d expected 1", hv_rise - h0); end
        n_cmp++; if (p_src_ip_o !== 32'h11223344) begin n_err++; $display("FAIL proto_src_ip got %h expected 11223344", p_src_ip_o); end
    endtask

    task automatic test_trunc();
        int d0 = drop_cnt, t0 = trunc_cnt;
        mk_hdr(8'd17, 32'hc0a80001, 32'hc0a80002, 16'h0005, 16'hebd1, 16'd40);
        add_payload(10, 16'h0500, 10, 9);
        send();
        wait_done();
        n_cmp++; if (trunc_cnt - t0 !== 1) begin n_err++; $display("FAIL trunc_pulse got %0d expected 1", trunc_cnt - t0); end
        n_cmp++; if (drop_cnt - d0 !== 0) begin n_err++; $display("FAIL trunc_drop got %0d expected 0", drop_cnt - d0); end
    endtask

    task automatic test_zero_len();
        int d0 = drop_cnt, h0 = hv_rise, c0 = hv_cycles;
        mk_hdr(8'd17, 32'hc0a80009, 32'hc0a8000a, 16'h0007, 16'hebd1, 16'd8);
        send();
        wait_done();
        n_cmp++; if (hv_rise - h0 !== 1 || hv_cycles - c0 !== 1) begin n_err++; $display("FAIL zero_hv got rises=%0d cycles=%0d expected 1 1", hv_rise - h0, hv_cycles - c0); end
        n_cmp++; if (drop_cnt - d0 !== 0) begin n_err++; $display("FAIL zero_drop got %0d expected 0", drop_cnt - d0); end
        mk_hdr(8'd17, 32'hc0a8000b, 32'hc0a8000c, 16'h0007, 16'hebd1, 16'd16);
        add_payload(4, 16'h0600, 4, 3);
        send();
        wait_done();
        n_cmp++; if (hv_rise - h0 !== 2) begin n_err++; $display("FAIL zero_next_hv got %0d expected 2", hv_rise - h0); end
    endtask

    task automatic test_short_hdr();
        int d0 = drop_cnt, h0 = hv_rise;
        mk_hdr(8'd17, 32'hc0a80001, 32'hc0a80002, 16'h0001, 16'hebd1, 16'd40);
        while (fr.size() > 6) void'(fr.pop_back());
        send();
        wait_done();
        n_cmp++; if (drop_cnt - d0 !== 1) begin n_err++; $display("FAIL short_drop got %0d expected 1", drop_cnt - d0); end
        n_cmp++; if (hv_rise - h0 !== 0) begin n_err++; $display("FAIL short_hv got %0d expected 0", hv_rise - h0); end
    endtask

`ifdef MT_UDP_RX_CSUM_CHECK_EN
    task automatic test_csum();
        int d0 = drop_cnt;
        mk_hdr(8'd17, 32'hac100001, 32'hac100002, 16'h0003, 16'hebd1, 16'd12);
        add_payload(2, 16'h0700, 2, 1);
        send();
        wait_done();
        n_cmp++; if (drop_cnt - d0 !== 0) begin n_err++; $display("FAIL csum_good_drop got %0d expected 0", drop_cnt - d0); end
        mk_hdr(8'd17, 32'hac100001, 32'hac100002, 16'h0003, 16'hebd1, 16'd12);
        fr[5] = fr[5] ^ 16'h0001;
        add_payload(2, 16'h0800, 0, -1);
        send();
        wait_done();
        n_cmp++; if (drop_cnt - d0 !== 1) begin n_err++; $display("FAIL csum_bad_drop got %0d expected 1", drop_cnt - d0); end
    endtask
`endif

    initial begin
        snk_i = '0;
        src_i = '0;
        test_reset();
        test_valid();
        test_padding();
        test_proto();
        test_trunc();
        test_zero_len();
        test_short_hdr();
`ifdef MT_UDP_RX_CSUM_CHECK_EN
        test_csum();
`endif
        thr = 0;
        test_valid();
        test_padding();
        test_trunc();
        test_zero_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
